perip_port_arbiter: RTL and testbench
=====================================

PERIP_PORT_ARBITER -- requirements
Module: perip_port_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 3, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter MEM_SIZE, default 10, giving the byte depth of the attached peripheral memory.
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port req_i, input, N_REQ, per-requester request level, held until ack.
REQ-006 The block SHALL have port we_i, input, N_REQ, per-requester write enable (1 = write, 0 = read).
REQ-007 The block SHALL have port be_i, input, 4*N_REQ, per-requester byte enables, requester k in bits [4k+3:4k].
REQ-008 The block SHALL have port addr_i, input, 32*N_REQ, per-requester byte address.
REQ-009 The block SHALL have port wdata_i, input, 32*N_REQ, per-requester write data.
REQ-010 The block SHALL have port ack_o, output, N_REQ, one-cycle completion pulse for requester k.
REQ-011 The block SHALL have port err_o, output, 1, out-of-range flag, valid only while some ack_o bit is high.
REQ-012 The block SHALL have port rdata_o, output, 32, read data of the last completed transaction.
REQ-013 The block SHALL have port grant_o, output, N_REQ, one-hot current owner; zero when idle.
REQ-014 The block SHALL have port mem_write_o, output, 1, write strobe to the memory peripheral port.
REQ-015 The block SHALL have port mem_be_o, output, 4, byte enables to the memory.
REQ-016 The block SHALL have port mem_wraddr_o, output, 32, write address to the memory.
REQ-017 The block SHALL have port mem_rdaddr_o, output, 32, read address to the memory.
REQ-018 The block SHALL have port mem_wdata_o, output, 32, write data to the memory.
REQ-019 The block SHALL have port mem_rdata_i, input, 32, combinational read data from the memory (masked by mem_be_o).

Function
REQ-020 FSM states SHALL be IDLE, ACCESS and DONE; reset state SHALL be IDLE.
REQ-021 IDLE: if any req_i bit is set, the winner SHALL be chosen round-robin, starting at last_grant+1 modulo N_REQ; we/be/addr/wdata of the winner SHALL be latched; next state SHALL be ACCESS; otherwise IDLE is held.
REQ-022 The range check SHALL be computed at latch time: err = 1 if any enabled lane i has addr+i >= MEM_SIZE, using a 33-bit sum so no wrap-around occurs.
REQ-023 ACCESS, exactly one cycle: mem_be_o = latched be, mem_rdaddr_o = mem_wraddr_o = latched addr, mem_wdata_o = latched wdata, and mem_write_o = we & ~err & ~rst_i.
REQ-024 If err=1 in ACCESS, mem_be_o SHALL be 0 and mem_write_o SHALL be 0.
REQ-025 At the end of ACCESS, rdata_o SHALL register mem_rdata_i for a read, or 0 for a write or an err access; last_grant SHALL take the winner index; next state SHALL be DONE.
REQ-026 DONE, exactly one cycle: ack_o[winner] = 1 and err_o = latched err; req_i is not sampled; next state SHALL be IDLE.
REQ-027 Timing: req_i rises in cycle t (IDLE) -> ACCESS in t+1 -> ack in t+2; peak throughput SHALL be one access per 3 cycles.
REQ-028 A requester SHALL drop req_i in the cycle after ack; a req_i still high in IDLE SHALL be treated as a new transaction.
REQ-029 grant_o SHALL be one-hot of the winner in ACCESS and DONE, and 0 in IDLE.
REQ-030 Outside ACCESS, all mem_* outputs SHALL be 0.
REQ-031 rdata_o SHALL hold its value until the next DONE.
REQ-032 be = 4'b0000 SHALL complete normally: no memory effect, rdata_o = 0, err = 0.
REQ-033 Requesters that deassert req_i before being granted SHALL simply be skipped; no request SHALL be starved, with worst-case wait (N_REQ-1)*3 cycles plus the current transaction.

Reset
REQ-034 rst_i high at a clock edge SHALL give: state IDLE, last_grant = N_REQ-1 (requester 0 highest after reset), ack_o = 0, err_o = 0, grant_o = 0, rdata_o = 0, latched fields = 0.
REQ-035 rst_i asserted during ACCESS SHALL suppress mem_write_o in that cycle and drop the transaction without ack.

Verification
REQ-036 The bench SHALL cover: req_i=001, we=1, be=1111, addr=0, wdata=0xA1B2C3D4 -> mem_write_o high in cycle t+1 only, ack_o=001 in t+2, err_o=0; a following read of addr 0 returns rdata_o=0xA1B2C3D4.
REQ-037 The bench SHALL cover: req_i=111 held continuously -> grants in order 0,1,2,0, each ack exactly 3 cycles apart.
REQ-038 The bench SHALL cover: requester 1 read with addr=8, be=1111 (MEM_SIZE 10) -> mem_be_o=0 and mem_write_o=0 throughout, ack_o=010, err_o=1, rdata_o=0.
REQ-039 The bench SHALL cover: read with addr=4, be=0101 after memory bytes 4..7 = 11,22,33,44 -> rdata_o=0x00330011.
REQ-040 The bench SHALL cover: rst_i pulsed in the ACCESS cycle of a write of 0xFFFFFFFF to addr 0 -> no memory change, no ack, next grant goes to requester 0.

Source files
------------

// File: rtl/perip_port_arbiter.sv
// Round-robin arbiter that funnels N_REQ requesters onto one byte-lane memory port,
// one access per IDLE -> ACCESS -> DONE pass, with a range check against MEM_SIZE.
module perip_port_arbiter #(
   parameter int N_REQ    = 3,
   parameter int MEM_SIZE = 10
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [N_REQ-1:0]      req_i,
   input  logic [N_REQ-1:0]      we_i,
   input  logic [4*N_REQ-1:0]    be_i,
   input  logic [32*N_REQ-1:0]   addr_i,
   input  logic [32*N_REQ-1:0]   wdata_i,
   output logic [N_REQ-1:0]      ack_o,
   output logic                  err_o,
   output logic [31:0]           rdata_o,
   output logic [N_REQ-1:0]      grant_o,
   output logic                  mem_write_o,
   output logic [3:0]            mem_be_o,
   output logic [31:0]           mem_wraddr_o,
   output logic [31:0]           mem_rdaddr_o,
   output logic [31:0]           mem_wdata_o,
   input  logic [31:0]           mem_rdata_i
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t            state_q;
   logic [IW-1:0]     lastGrant_q;
   logic [IW-1:0]     winner_q;
   logic              we_q;
   logic [3:0]        be_q;
   logic [31:0]       addr_q;
   logic [31:0]       wdata_q;
   logic              err_q;
   logic [31:0]       rdata_q;
   logic [N_REQ-1:0]  ack_q;
   logic              errOut_q;
   logic [N_REQ-1:0]  grant_q;

   logic              reqValid;
   logic [IW-1:0]     winIdx_d;
   logic [IW:0]       candSum;
   logic [IW-1:0]     candIdx;
   logic              we_d;
   logic [3:0]        be_d;
   logic [31:0]       addr_d;
   logic [31:0]       wdata_d;
   logic              err_d;
   logic              inAccess;

   // Search starts one past the last winner, so requester 0 leads after reset.
   always_comb begin
      reqValid = 1'b0;
      winIdx_d = '0;
      candSum  = '0;
      candIdx  = '0;
      for (int off = 1; off <= N_REQ; off++) begin
         candSum = {1'b0, lastGrant_q} + (IW+1)'(off);
         if (candSum >= (IW+1)'(N_REQ)) begin
            candSum = candSum - (IW+1)'(N_REQ);
         end
         candIdx = candSum[IW-1:0];
         if (!reqValid && req_i[candIdx]) begin
            reqValid = 1'b1;
            winIdx_d = candIdx;
         end
      end
   end

   // The 33-bit sum keeps addresses near 2^32 from wrapping back into range.
   always_comb begin
      we_d    = 1'b0;
      be_d    = '0;
      addr_d  = '0;
      wdata_d = '0;
      err_d   = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (winIdx_d == IW'(k)) begin
            we_d    = we_i[k];
            be_d    = be_i[4*k +: 4];
            addr_d  = addr_i[32*k +: 32];
            wdata_d = wdata_i[32*k +: 32];
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (be_d[i] && (({1'b0, addr_d} + 33'(i)) >= 33'(MEM_SIZE))) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         lastGrant_q <= IW'(N_REQ-1);
         winner_q    <= '0;
         we_q        <= 1'b0;
         be_q        <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         ack_q       <= '0;
         errOut_q    <= 1'b0;
         grant_q     <= '0;
      end else begin
         ack_q    <= '0;
         errOut_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (reqValid) begin
                  winner_q <= winIdx_d;
                  we_q     <= we_d;
                  be_q     <= be_d;
                  addr_q   <= addr_d;
                  wdata_q  <= wdata_d;
                  err_q    <= err_d;
                  grant_q  <= N_REQ'(1) << winIdx_d;
                  state_q  <= ACCESS;
               end
            end
            ACCESS: begin
               rdata_q     <= (we_q || err_q) ? 32'h0 : mem_rdata_i;
               lastGrant_q <= winner_q;
               ack_q       <= grant_q;
               errOut_q    <= err_q;
               state_q     <= DONE;
            end
            DONE: begin
               grant_q <= '0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // The memory port is live only during ACCESS; a range error blanks the lanes.
   assign inAccess     = (state_q == ACCESS);
   assign mem_be_o     = (inAccess && !err_q) ? be_q : 4'b0000;
   assign mem_write_o  = inAccess & we_q & ~err_q & ~rst_i;
   assign mem_wraddr_o = inAccess ? addr_q : 32'h0;
   assign mem_rdaddr_o = inAccess ? addr_q : 32'h0;
   assign mem_wdata_o  = inAccess ? wdata_q : 32'h0;

   assign ack_o   = ack_q;
   assign err_o   = errOut_q;
   assign grant_o = grant_q;
   assign rdata_o = rdata_q;

endmodule

// File: tb/tb_perip_port_arbiter.sv
// Bench for perip_port_arbiter: a byte memory model on the mem_* port and a
// scoreboard of expected acks (owner, err, rdata) filled as requests are driven.
module tb_perip_port_arbiter;

   localparam int N_REQ    = 3;
   localparam int MEM_SIZE = 10;

   logic                 clk_i = 1'b0;
   logic                 rst_i;
   logic [N_REQ-1:0]     req_i;
   logic [N_REQ-1:0]     we_i;
   logic [4*N_REQ-1:0]   be_i;
   logic [32*N_REQ-1:0]  addr_i;
   logic [32*N_REQ-1:0]  wdata_i;
   logic [N_REQ-1:0]     ack_o;
   logic                 err_o;
   logic [31:0]          rdata_o;
   logic [N_REQ-1:0]     grant_o;
   logic                 mem_write_o;
   logic [3:0]           mem_be_o;
   logic [31:0]          mem_wraddr_o;
   logic [31:0]          mem_rdaddr_o;
   logic [31:0]          mem_wdata_o;
   logic [31:0]          mem_rdata_i;

   typedef struct {
      int          idx;
      logic        err;
      logic [31:0] rdata;
   } expT;

   expT         expQ[$];
   int          testsRun    = 0;
   int          testsFailed = 0;
   int          cyc         = 0;
   logic [7:0]  mem    [MEM_SIZE];
   logic [7:0]  refMem [MEM_SIZE];
   logic [63:0] rdA;

   perip_port_arbiter #(.N_REQ(N_REQ), .MEM_SIZE(MEM_SIZE)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_i        (req_i),
      .we_i         (we_i),
      .be_i         (be_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .ack_o        (ack_o),
      .err_o        (err_o),
      .rdata_o      (rdata_o),
      .grant_o      (grant_o),
      .mem_write_o  (mem_write_o),
      .mem_be_o     (mem_be_o),
      .mem_wraddr_o (mem_wraddr_o),
      .mem_rdaddr_o (mem_rdaddr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_rdata_i  (mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   // Peripheral memory: lane i maps to byte addr+i, read data masked by mem_be_o.
   always_comb begin
      mem_rdata_i = '0;
      rdA         = '0;
      for (int i = 0; i < 4; i++) begin
         rdA = {32'h0, mem_rdaddr_o} + 64'(i);
         if (mem_be_o[i] && rdA < 64'(MEM_SIZE)) begin
            mem_rdata_i[8*i +: 8] = mem[int'(rdA[31:0])];
         end
      end
   end

   always @(posedge clk_i) begin
      if (mem_write_o) begin
         for (int i = 0; i < 4; i++) begin
            if (mem_be_o[i] && ({32'h0, mem_wraddr_o} + 64'(i)) < 64'(MEM_SIZE)) begin
               mem[int'(mem_wraddr_o) + i] <= mem_wdata_o[8*i +: 8];
            end
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   function automatic logic [N_REQ-1:0] oneHot(input int k);
      oneHot    = '0;
      oneHot[k] = 1'b1;
   endfunction

   function automatic logic rangeErr(input logic [31:0] addr, input logic [3:0] be);
      rangeErr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (be[i] && ({32'h0, addr} + 64'(i)) >= 64'(MEM_SIZE)) rangeErr = 1'b1;
      end
   endfunction

   task automatic pushExpect(input int k, input logic we, input logic [3:0] be,
                             input logic [31:0] addr, input logic [31:0] wdata);
      expT e;
      int  a;
      e.idx   = k;
      e.err   = rangeErr(addr, be);
      e.rdata = '0;
      if (!e.err) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               a = int'(addr) + i;
               if (we) refMem[a] = wdata[8*i +: 8];
               else    e.rdata[8*i +: 8] = refMem[a];
            end
         end
      end
      expQ.push_back(e);
   endtask

   task automatic applyStimulus(input int k, input logic we, input logic [3:0] be,
                                input logic [31:0] addr, input logic [31:0] wdata);
      req_i[k]             = 1'b1;
      we_i[k]              = we;
      be_i[4*k +: 4]       = be;
      addr_i[32*k +: 32]   = addr;
      wdata_i[32*k +: 32]  = wdata;
      pushExpect(k, we, be, addr, wdata);
   endtask

   task automatic scoreAck();
      expT e;
      if (expQ.size() == 0) begin
         checkOutput("unexpectedAck", 32'(ack_o), 32'h0);
      end else begin
         e = expQ.pop_front();
         checkOutput("ackOwner", 32'(ack_o), 32'(oneHot(e.idx)));
         checkOutput("ackErr", 32'(err_o), 32'(e.err));
         checkOutput("ackRdata", rdata_o, e.rdata);
      end
   endtask

   always @(negedge clk_i) begin
      if (ack_o !== '0) scoreAck();
   end

   task automatic waitAnyAck(output int c);
      c = -1;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk_i);
         if (ack_o !== '0) begin
            c = cyc;
            break;
         end
      end
      if (c < 0) checkOutput("ackTimeout", 32'h0, 32'h1);
   endtask

   // One isolated transaction with cycle-exact checks of IDLE, ACCESS and DONE.
   task automatic runSingle(input int k, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata);
      logic err;
      @(posedge clk_i);
      #1;
      applyStimulus(k, we, be, addr, wdata);
      err = rangeErr(addr, be);
      @(negedge clk_i);
      checkOutput("idleGrant", 32'(grant_o), 32'h0);
      checkOutput("idleWrite", 32'(mem_write_o), 32'h0);
      @(negedge clk_i);
      checkOutput("accessGrant", 32'(grant_o), 32'(oneHot(k)));
      checkOutput("accessWrite", 32'(mem_write_o), 32'(we && !err));
      checkOutput("accessBe", 32'(mem_be_o), err ? 32'h0 : 32'(be));
      checkOutput("accessRdAddr", mem_rdaddr_o, addr);
      checkOutput("accessWrAddr", mem_wraddr_o, addr);
      checkOutput("accessWdata", mem_wdata_o, wdata);
      @(negedge clk_i);
      checkOutput("doneAck", 32'(ack_o), 32'(oneHot(k)));
      checkOutput("doneWrite", 32'(mem_write_o), 32'h0);
      @(posedge clk_i);
      #1;
      req_i[k] = 1'b0;
   endtask

   initial begin
      int ackCyc;
      int prevCyc;
      rst_i   = 1'b1;
      req_i   = '0;
      we_i    = '0;
      be_i    = '0;
      addr_i  = '0;
      wdata_i = '0;
      prevCyc = 0;
      for (int i = 0; i < MEM_SIZE; i++) refMem[i] = 8'h00;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;

      @(negedge clk_i);
      checkOutput("rstGrant", 32'(grant_o), 32'h0);
      checkOutput("rstAck", 32'(ack_o), 32'h0);
      checkOutput("rstErr", 32'(err_o), 32'h0);
      checkOutput("rstRdata", rdata_o, 32'h0);
      checkOutput("rstMemBe", 32'(mem_be_o), 32'h0);
      checkOutput("rstMemWdata", mem_wdata_o, 32'h0);

      // Write then read back a full word at address 0.
      runSingle(0, 1'b1, 4'b1111, 32'h0, 32'hA1B2C3D4);
      runSingle(2, 1'b0, 4'b1111, 32'h0, 32'h0);
      checkOutput("readBackWord", rdata_o, 32'hA1B2C3D4);

      // All three requesters held: grants rotate 0,1,2,0 three cycles apart.
      @(posedge clk_i);
      #1;
      applyStimulus(0, 1'b0, 4'b1111, 32'h0, 32'h0);
      applyStimulus(1, 1'b0, 4'b0011, 32'h2, 32'h0);
      applyStimulus(2, 1'b1, 4'b1111, 32'h6, 32'h12345678);
      pushExpect(0, 1'b0, 4'b1111, 32'h0, 32'h0);
      for (int n = 0; n < 4; n++) begin
         waitAnyAck(ackCyc);
         if (n > 0) checkOutput("ackSpacing", 32'(ackCyc - prevCyc), 32'd3);
         prevCyc = ackCyc;
      end
      @(posedge clk_i);
      #1;
      req_i = '0;

      // Out-of-range read and range boundaries, including the 32-bit wrap case.
      runSingle(1, 1'b0, 4'b1111, 32'h8, 32'h0);
      checkOutput("errRdata", rdata_o, 32'h0);
      runSingle(2, 1'b0, 4'b0111, 32'h7, 32'h0);
      checkOutput("edgeRdata", rdata_o, 32'h00123456);
      runSingle(0, 1'b0, 4'b1000, 32'h7, 32'h0);
      runSingle(1, 1'b0, 4'b0001, 32'hFFFFFFFF, 32'h0);
      runSingle(2, 1'b1, 4'b0000, 32'h0, 32'hDEADBEEF);

      // Sparse byte enables on a freshly written word.
      runSingle(0, 1'b1, 4'b1111, 32'h4, 32'h44332211);
      runSingle(2, 0, 4'b0101, 32'h4, 32'h0);
      checkOutput("sparseRdata", rdata_o, 32'h00330011);

      // Leave requester 0 as last winner, then abort a write with reset in ACCESS.
      runSingle(0, 1'b0, 4'b1111, 32'h0, 32'h0);
      @(posedge clk_i);
      #1;
      req_i[2]          = 1'b1;
      we_i[2]           = 1'b1;
      be_i[8 +: 4]      = 4'b1111;
      addr_i[64 +: 32]  = 32'h0;
      wdata_i[64 +: 32] = 32'hFFFFFFFF;
      @(negedge clk_i);
      @(negedge clk_i);
      checkOutput("abortGrant", 32'(grant_o), 32'(oneHot(2)));
      rst_i = 1'b1;
      #1;
      checkOutput("rstWriteSuppress", 32'(mem_write_o), 32'h0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      req_i = '0;
      @(negedge clk_i);
      checkOutput("abortAck", 32'(ack_o), 32'h0);
      checkOutput("abortGrantIdle", 32'(grant_o), 32'h0);
      checkOutput("abortRdata", rdata_o, 32'h0);
      @(negedge clk_i);
      checkOutput("abortNoLateAck", 32'(ack_o), 32'h0);

      @(posedge clk_i);
      #1;
      applyStimulus(0, 1'b0, 4'b1111, 32'h0, 32'h0);
      applyStimulus(1, 1'b0, 4'b1111, 32'h0, 32'h0);
      waitAnyAck(ackCyc);
      checkOutput("postRstOwner", 32'(ack_o), 32'(oneHot(0)));
      @(posedge clk_i);
      #1;
      req_i[0] = 1'b0;
      waitAnyAck(ackCyc);
      @(posedge clk_i);
      #1;
      req_i[1] = 1'b0;

      repeat (4) @(negedge clk_i);
      checkOutput("queueEmpty", 32'(expQ.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
